// File: rtl/attopu_run_ctrl.sv
// Run controller for the attopu core: loads a program image into
// instruction memory, then sequences processor reset/enable through
// run, single-step, halt and breakpoint stops.
module attopu_run_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    input  logic [15:0]       ld_data_i,
    input  logic              ld_last_i,
    input  logic              cmd_run_i,
    input  logic              cmd_step_i,
    input  logic              cmd_halt_i,
    input  logic              cmd_load_i,
    input  logic              bp_en_i,
    input  logic [15:0]       bp_addr_i,
    input  logic [15:0]       pc_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [15:0]       imem_wdata_o,
    output logic              cpu_rst_o,
    output logic              cpu_en_o,
    output logic [2:0]        state_o,
    output logic [ADDR_W:0]   load_count_o,
    output logic              step_done_o,
    output logic              bp_hit_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_LOAD = 3'd0,
        S_IDLE = 3'd1,
        S_RUN  = 3'd2,
        S_HALT = 3'd3,
        S_STEP = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic            ld_ready_q, cpu_rst_q, resume_q, step_done_q, bp_hit_q;
    logic            accept, in_exec, bp_match, last_slot;

    assign accept    = ld_valid_i && ld_ready_q;
    assign last_slot = (cnt_q == (ADDR_W+1)'(DEPTH - 1));
    assign in_exec   = (state_q == S_RUN) || (state_q == S_STEP);
    // The first enabled cycle after a resume skips the match so the core
    // can execute the instruction it stopped on.
    assign bp_match  = in_exec && bp_en_i && (pc_i == bp_addr_i) && !resume_q;

    assign ld_ready_o   = ld_ready_q;
    assign imem_we_o    = accept;
    assign imem_addr_o  = cnt_q[ADDR_W-1:0];
    assign imem_wdata_o = ld_data_i;
    assign cpu_rst_o    = cpu_rst_q;
    assign cpu_en_o     = in_exec && !bp_match;
    assign state_o      = state_q;
    assign load_count_o = cnt_q;
    assign step_done_o  = step_done_q;
    assign bp_hit_o     = bp_hit_q;

    // Next-state decode; halt > load > step > run, illegal commands ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (ld_last_i || last_slot) state_d = S_IDLE;
                end
            end
            S_IDLE, S_HALT: begin
                if (cmd_load_i)      state_d = S_LOAD;
                else if (cmd_step_i) state_d = S_STEP;
                else if (cmd_run_i)  state_d = S_RUN;
            end
            S_RUN:   if (cmd_halt_i || bp_match) state_d = S_HALT;
            S_STEP:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_LOAD && state_q != S_LOAD) cnt_d = '0;
    end

    // State, counter and registered control outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            ld_ready_q  <= 1'b0;
            cpu_rst_q   <= 1'b1;
            resume_q    <= 1'b0;
            step_done_q <= 1'b0;
            bp_hit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ld_ready_q  <= (state_d == S_LOAD);
            cpu_rst_q   <= (state_d == S_LOAD) || (state_d == S_IDLE);
            resume_q    <= (state_q == S_HALT) &&
                           ((state_d == S_RUN) || (state_d == S_STEP));
            step_done_q <= (state_q == S_STEP) && !bp_match;
            if (bp_match)
                bp_hit_q <= 1'b1;
            else if (state_q == S_HALT && state_d != S_HALT)
                bp_hit_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_attopu_run_ctrl.sv
// Bench for attopu_run_ctrl: directed scenarios followed by random
// command/loader traffic, all checked each cycle against a mode-level model.
module tb_attopu_run_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_valid = 1'b0, ld_last = 1'b0;
    logic [15:0]   ld_data = '0;
    logic          c_run = 1'b0, c_step = 1'b0, c_halt = 1'b0, c_load = 1'b0;
    logic          bp_en = 1'b0;
    logic [15:0]   bp_addr = '0, pc = '0;
    logic          ld_ready, imem_we, cpu_rst, cpu_en, step_done, bp_hit;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic [2:0]    state;
    logic [AW:0]   load_count;

    attopu_run_ctrl #(.ADDR_W(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_data_i(ld_data),
        .ld_last_i(ld_last),
        .cmd_run_i(c_run), .cmd_step_i(c_step), .cmd_halt_i(c_halt),
        .cmd_load_i(c_load),
        .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc),
        .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
        .cpu_rst_o(cpu_rst), .cpu_en_o(cpu_en), .state_o(state),
        .load_count_o(load_count), .step_done_o(step_done), .bp_hit_o(bp_hit)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    // Model: mode numbers follow the published state codes.
    int          m_mode, m_cnt;
    bit          m_bp, m_res, m_sd, m_fresh;
    logic [15:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_exec();
        return (m_mode == 2) || (m_mode == 4);
    endfunction

    function automatic bit m_match();
        return m_exec() && bp_en && (pc == bp_addr) && !m_res;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_bp = 0; m_res = 0; m_sd = 0; m_fresh = 1;
        m_pc = '0;
    endtask

    task automatic check_outs();
        bit rdy;
        rdy = (m_mode == 0) && !m_fresh;
        chk("state", state, m_mode);
        chk("load_count", load_count, m_cnt);
        chk("ld_ready", ld_ready, rdy);
        chk("imem_we", imem_we, rdy && ld_valid);
        if (rdy && ld_valid) begin
            chk("imem_addr", imem_addr, m_cnt);
            chk("imem_wdata", imem_wdata, ld_data);
        end
        chk("cpu_rst", cpu_rst, (m_mode == 0) || (m_mode == 1));
        chk("cpu_en", cpu_en, m_exec() && !m_match());
        chk("step_done", step_done, m_sd);
        chk("bp_hit", bp_hit, m_bp);
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        int  nm;
        bit  mt;
        mt = m_match();
        nm = m_mode;
        if (m_mode <= 1) m_pc = '0;
        else if (m_exec() && !mt) m_pc = m_pc + 16'd1;
        case (m_mode)
            0: if (!m_fresh && ld_valid) begin
                   m_cnt++;
                   if (ld_last || m_cnt == DEPTH) nm = 1;
               end
            1, 3: nm = c_load ? 0 : c_step ? 4 : c_run ? 2 : m_mode;
            2: if (c_halt || mt) nm = 3;
            default: nm = 3;
        endcase
        if (mt) m_bp = 1;
        else if (m_mode == 3 && nm != 3) m_bp = 0;
        m_sd  = (m_mode == 4) && !mt;
        m_res = (m_mode == 3) && (nm == 2 || nm == 4);
        if (nm == 0 && m_mode != 0) m_cnt = 0;
        m_mode  = nm;
        m_fresh = 0;
    endtask

    task automatic clr();
        ld_valid = 0; ld_last = 0; c_run = 0; c_step = 0; c_halt = 0; c_load = 0;
    endtask

    // One cycle: inputs already driven at the falling edge.
    task automatic tick();
        pc = m_pc;
        #1;
        check_outs();
        model_edge();
        @(negedge clk);
        clr();
        pc = m_pc;
    endtask

    task automatic do_reset();
        #3 rst_n = 0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_count", load_count, 0);
        chk("rst_step_done", step_done, 0);
        chk("rst_bp_hit", bp_hit, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        clr();
        pc = m_pc;
    endtask

    initial begin
        bit seen;
        model_reset();
        @(negedge clk);
        do_reset();
        tick();

        // Three-word image, last flagged on the third word.
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1; ld_data = 16'h1111 * (i + 1); ld_last = (i == 2);
            tick();
        end
        #1;
        chk("img3_state", state, 1);
        chk("img3_count", load_count, 3);
        chk("img3_cpu_rst", cpu_rst, 1);

        // Six words without last: only DEPTH are taken.
        c_load = 1; tick();
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1; ld_data = 16'hA000 + 16'(i); tick();
        end
        #1;
        chk("full_state", state, 1);
        chk("full_count", load_count, 4);
        chk("full_ready", ld_ready, 0);

        // Run, then halt after five cycles.
        c_run = 1; tick();
        #1;
        chk("run_en", cpu_en, 1);
        chk("run_rst", cpu_rst, 0);
        repeat (4) tick();
        c_halt = 1; tick();
        #1;
        chk("halt_state", state, 3);
        chk("halt_en", cpu_en, 0);

        // Single step out of halt.
        c_step = 1; tick();
        #1;
        chk("step_en", cpu_en, 1);
        tick();
        #1;
        chk("step_halt", state, 3);
        chk("step_pulse", step_done, 1);
        chk("step_en_off", cpu_en, 0);
        tick();
        #1;
        chk("step_pulse_end", step_done, 0);

        // Breakpoint at 0x0004 after a fresh load (pc restarts at 0).
        c_load = 1; tick();
        ld_valid = 1; ld_last = 1; ld_data = 16'h5555; tick();
        bp_en = 1; bp_addr = 16'h0004;
        c_run = 1; tick();
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (state == 3) seen = 1;
            else tick();
        end
        chk("bp_reached", seen, 1);
        chk("bp_flag", bp_hit, 1);
        c_run = 1; tick();
        #1;
        chk("bp_resume_en", cpu_en, 1);
        tick();
        #1;
        chk("bp_cleared", bp_hit, 0);
        chk("bp_past", state, 2);
        bp_en = 0;

        // Halt beats load; reset aborts a run.
        c_halt = 1; c_load = 1; tick();
        #1;
        chk("prio_state", state, 3);
        c_run = 1; tick();
        tick();
        do_reset();
        tick();

        // Random traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                ld_valid = $urandom_range(0, 1);
                ld_last  = ($urandom_range(0, 5) == 0);
                ld_data  = 16'($urandom);
                c_run    = ($urandom_range(0, 7) == 0);
                c_step   = ($urandom_range(0, 7) == 0);
                c_halt   = ($urandom_range(0, 9) == 0);
                c_load   = ($urandom_range(0, 15) == 0);
                bp_en    = $urandom_range(0, 1);
                bp_addr  = $urandom_range(0, 1) ? m_pc + 16'($urandom_range(0, 2))
                                                : 16'($urandom_range(0, 7));
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/attopu_run_ctrl.md
ATTOPU_RUN_CTRL -- requirements
Module: attopu_run_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory address width; DEPTH = 2**ADDR_W words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ld_valid  input  1  loader word valid.
REQ-005 ld_ready  output  1  loader word accepted when ld_valid && ld_ready at a rising edge.
REQ-006 ld_data  input  16  program word.
REQ-007 ld_last  input  1  qualifies final word of a program image.
REQ-008 cmd_run / cmd_step / cmd_halt / cmd_load  input  1 each  single-cycle command pulses.
REQ-009 bp_en  input  1  breakpoint enable; bp_addr  input  16  breakpoint PC.
REQ-010 pc  input  16  current processor PC.
REQ-011 imem_we  output  1  instruction-memory write strobe; imem_addr  output  ADDR_W; imem_wdata  output  16.
REQ-012 cpu_rst  output  1  active-high reset to processor; cpu_en  output  1  processor clock enable.
REQ-013 state  output  3  encoded state; load_count  output  ADDR_W+1  words loaded; step_done  output  1  pulse; bp_hit  output  1  sticky flag.

Function
REQ-014 States: LOAD=0, IDLE=1, RUN=2, HALT=3, STEP=4; other encodings SHALL return to IDLE next cycle.
REQ-015 LOAD: ld_ready=1, cpu_rst=1, cpu_en=0; each accepted word drives imem_we=1, imem_addr=load_count[ADDR_W-1:0], imem_wdata=ld_data combinationally; load_count increments at the edge.
REQ-016 LOAD exit to IDLE after accepting a word with ld_last=1, or after accepting the word at address DEPTH-1 (load_count reaches DEPTH); no address wrap; further ld_valid ignored (ld_ready=0).
REQ-017 IDLE: cpu_rst=1, cpu_en=0, ld_ready=0; cmd_run -> RUN, cmd_step -> STEP, cmd_load -> LOAD.
REQ-018 RUN: cpu_rst=0, cpu_en=1 unless breakpoint condition; cmd_halt -> HALT next cycle (cpu_en stays 1 in the command cycle).
REQ-019 Breakpoint: in RUN or STEP, if bp_en && pc==bp_addr, cpu_en SHALL be 0 that same cycle (combinational), state -> HALT, bp_hit set; instruction at bp_addr not executed.
REQ-020 Breakpoint on resume: first enabled cycle after leaving HALT via cmd_run/cmd_step SHALL ignore the breakpoint match, so execution can proceed past it.
REQ-021 HALT: cpu_rst=0, cpu_en=0; processor state preserved; cmd_run -> RUN, cmd_step -> STEP, cmd_load -> LOAD; bp_hit cleared on leaving HALT.
REQ-022 STEP: cpu_rst=0, cpu_en=1 for exactly one cycle, then HALT with step_done=1 for one cycle in the first HALT cycle.
REQ-023 Simultaneous commands priority: cmd_halt > cmd_load > cmd_step > cmd_run; commands not legal in the current state ignored.
REQ-024 Entering LOAD from any state clears load_count to 0 and asserts cpu_rst the same cycle the state becomes LOAD.
REQ-025 imem_we SHALL be 0 in every state except LOAD.

Reset
REQ-026 While rst_n=0: state=LOAD, load_count=0, cpu_rst=1, cpu_en=0, step_done=0, bp_hit=0, imem_we=0; ld_ready=1 from the first edge after release.
REQ-027 Reset assertion mid-load or mid-run SHALL abort immediately; partially loaded memory contents are not cleared.

Verification
REQ-028 Load 3 words 0x1111,0x2222,0x3333 (last on third) -> writes addr 0,1,2; load_count=3; state=IDLE; cpu_rst=1.
REQ-029 ADDR_W=2, stream 6 words ld_last=0 -> 4 writes addr 0..3; ld_ready=0 after fourth; state=IDLE; load_count=4.
REQ-030 IDLE, cmd_run -> cpu_rst=0, cpu_en=1 next cycle; cmd_halt after 5 cycles -> cpu_en=0 next cycle, state=HALT.
REQ-031 HALT, cmd_step -> cpu_en=1 exactly one cycle, then state=HALT, step_done one-cycle pulse.
REQ-032 RUN, bp_en=1 bp_addr=0x0004, pc reaches 0x0004 -> cpu_en=0 same cycle, state=HALT, bp_hit=1; cmd_run -> pc advances past 0x0004, bp_hit=0.
REQ-033 RUN, cmd_halt and cmd_load same cycle -> HALT; rst_n pulsed low in RUN -> state=LOAD, cpu_rst=1 asynchronously.
